round_ctrl: RTL and testbench
=============================

ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter WINDOW, 32'd25000000, reaction window in clock cycles per zombie (≥2).
REQ-002 Parameter HOLD, 32'd5000000, post-result hold time in clock cycles (≥1).
REQ-003 Parameter MAX_ROUNDS, 8'd20, rounds per game (≥1).
REQ-004 Parameter LIVES_INIT, 2'd3, lives at game start (≥1).
REQ-005 clock  input  1  single system clock; all logic on posedge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse: begin new game.
REQ-008 shoot  input  4  one-cycle pulses, one bit per lane button, already debounced.
REQ-009 hit  output  1  one-cycle pulse: correct lane shot.
REQ-010 fail  output  1  one-cycle pulse: wrong lane or timeout.
REQ-011 end_flag  output  1  level: no game running (idle or over).
REQ-012 zombie_lane  output  2  lane of current zombie.
REQ-013 zombie_vld  output  1  level: zombie visible and awaiting a shot.
REQ-014 score  output  8  hits this game.
REQ-015 lives  output  2  remaining lives.

Function
REQ-016 The FSM SHALL have states IDLE, SPAWN, WAIT, HOLD, OVER.
REQ-017 An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) SHALL advance every cycle, never reaching zero.
REQ-018 In IDLE or OVER, a start pulse SHALL clear score, load lives=LIVES_INIT, clear the round counter, drop end_flag next cycle and enter SPAWN.
REQ-019 start SHALL be ignored in SPAWN, WAIT and HOLD.
REQ-020 SPAWN SHALL last exactly one cycle, latch zombie_lane=lfsr[1:0], set zombie_vld=1, clear the timer, enter WAIT.
REQ-021 In WAIT, if shoot[zombie_lane]=1 the block SHALL pulse hit for one cycle, increment score (saturating at 255), clear zombie_vld, enter HOLD.
REQ-022 In WAIT, if shoot≠0 and shoot[zombie_lane]=0 the block SHALL pulse fail, decrement lives (saturating at 0), clear zombie_vld, enter HOLD.
REQ-023 In WAIT, if no shoot bit is set and the timer equals WINDOW-1 the block SHALL treat it as fail per REQ-022.
REQ-024 If the correct bit and other bits are set simultaneously, hit SHALL win; a shot SHALL win over a coincident timeout.
REQ-025 Each hit/fail resolution SHALL increment the round counter by one.
REQ-026 HOLD SHALL last exactly HOLD cycles with shoot ignored, then enter OVER if lives=0 or round counter=MAX_ROUNDS, otherwise SPAWN.
REQ-027 hit and fail SHALL never be asserted together and SHALL each be high at most one cycle per round.
REQ-028 end_flag SHALL be 1 in IDLE and OVER, 0 otherwise; score and lives SHALL hold their final values in OVER.

Reset
REQ-029 On reset low: state IDLE, end_flag=1, hit=0, fail=0, zombie_vld=0, zombie_lane=0, score=0, lives=LIVES_INIT, timer=0, round counter=0, LFSR=8'hA5.
REQ-030 Reset asserted mid-game SHALL abort immediately with no hit/fail pulse after release.

Structure
REQ-031 A shared package SHALL hold the state encoding, LFSR seed and tap constants, and parameter defaults.
REQ-032 The LFSR SHALL be one sub-module, lfsr8 (clock, reset, 8-bit value out).

Verification (WINDOW=8, HOLD=4, MAX_ROUNDS=3, LIVES_INIT=2)
REQ-033 Reset release, no start -> end_flag=1, score=0, lives=2, zombie_vld=0 indefinitely.
REQ-034 start, then shoot correct lane 3 cycles after zombie_vld -> hit 1 cycle, score=1, zombie_vld=0, SPAWN exactly 4 cycles after hit.
REQ-035 start, no shoot -> fail exactly 8 cycles after zombie_vld rises, lives=1.
REQ-036 Wrong-lane shoot, then timeout on next round -> lives=0, end_flag=1 after HOLD, score=0; further shoot ignored.
REQ-037 Three correct hits -> score=3, end_flag=1; start in OVER -> score=0, lives=2, new zombie; start during WAIT ignored.
REQ-038 shoot=4'b1111 coincident with timeout cycle -> hit only; reset low during WAIT -> all outputs at REQ-029 values.

Source files
------------

// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the zombie round controller.
// Holds the FSM encoding, LFSR seed/taps and parameter defaults.
package round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_WAIT,
    ST_HOLD,
    ST_OVER
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 as a bit mask
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [31:0] WINDOW_DEF     = 32'd25000000;
  localparam logic [31:0] HOLD_DEF       = 32'd5000000;
  localparam logic [7:0]  MAX_ROUNDS_DEF = 8'd20;
  localparam logic [1:0]  LIVES_INIT_DEF = 2'd3;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR.
// Seeded non-zero, so it never locks up at zero.
module lfsr8
  import round_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) value <= LFSR_SEED;
    else        value <= lfsr_next(value);
  end

endmodule

// File: rtl/round_ctrl.sv
// Round controller for the zombie lane shooting game.
// Spawns a zombie, times the reaction window, scores hits.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter logic [31:0] WINDOW     = WINDOW_DEF,
  parameter logic [31:0] HOLD       = HOLD_DEF,
  parameter logic [7:0]  MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter logic [1:0]  LIVES_INIT = LIVES_INIT_DEF
)(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] shoot,
  output logic       hit,
  output logic       fail,
  output logic       end_flag,
  output logic [1:0] zombie_lane,
  output logic       zombie_vld,
  output logic [7:0] score,
  output logic [1:0] lives
);

  state_t      state;
  logic [31:0] timer;
  logic [7:0]  rounds;
  logic [7:0]  lfsr;
  logic [5:0]  lfsr_unused;
  logic        good;
  logic        miss;
  logic        hold_done;
  logic        game_done;

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr)
  );

  assign lfsr_unused = lfsr[7:2];

  // a correct bit wins over wrong bits and the timeout
  assign good = shoot[zombie_lane];
  assign miss = !good &&
                ((|shoot) || (timer == WINDOW - 32'd1));

  assign hold_done = (timer == HOLD - 32'd1);
  assign game_done = (lives == 2'd0) ||
                     (rounds == MAX_ROUNDS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      end_flag    <= 1'b1;
      hit         <= 1'b0;
      fail        <= 1'b0;
      zombie_vld  <= 1'b0;
      zombie_lane <= 2'd0;
      score       <= 8'd0;
      lives       <= LIVES_INIT;
      timer       <= 32'd0;
      rounds      <= 8'd0;
    end else begin
      hit  <= 1'b0;
      fail <= 1'b0;
      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score    <= 8'd0;
            lives    <= LIVES_INIT;
            rounds   <= 8'd0;
            end_flag <= 1'b0;
            state    <= ST_SPAWN;
          end
        end
        ST_SPAWN: begin
          zombie_lane <= lfsr[1:0];
          zombie_vld  <= 1'b1;
          timer       <= 32'd0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          unique case (1'b1)
            good: begin
              hit        <= 1'b1;
              score      <= (score == 8'hFF) ?
                            score : score + 8'd1;
              zombie_vld <= 1'b0;
              rounds     <= rounds + 8'd1;
              timer      <= 32'd0;
              state      <= ST_HOLD;
            end
            miss: begin
              fail       <= 1'b1;
              lives      <= (lives == 2'd0) ?
                            lives : lives - 2'd1;
              zombie_vld <= 1'b0;
              rounds     <= rounds + 8'd1;
              timer      <= 32'd0;
              state      <= ST_HOLD;
            end
            default: timer <= timer + 32'd1;
          endcase
        end
        ST_HOLD: begin
          if (hold_done) begin
            timer <= 32'd0;
            if (game_done) begin
              end_flag <= 1'b1;
              state    <= ST_OVER;
            end else begin
              state <= ST_SPAWN;
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          end_flag <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl with a small
// per-round game model and an independent LFSR model.
module tb_round_ctrl;

  localparam int WIN  = 8;
  localparam int HLD  = 4;
  localparam int MAXR = 3;
  localparam int LIV  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] shoot = 4'h0;
  logic       hit;
  logic       fail;
  logic       end_flag;
  logic [1:0] zombie_lane;
  logic       zombie_vld;
  logic [7:0] score;
  logic [1:0] lives;

  int n_err = 0;
  int n_chk = 0;
  int m_score;
  int m_lives;
  int m_rounds;
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  typedef struct {
    bit do_start;
    int kind;
    int dly;
    bit inj;
    int exp_score;
    int exp_lives;
    bit exp_end;
  } vec_t;

  vec_t tbl [8];

  round_ctrl #(
    .WINDOW     (32'd8),
    .HOLD       (32'd4),
    .MAX_ROUNDS (8'd3),
    .LIVES_INIT (2'd2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .shoot       (shoot),
    .hit         (hit),
    .fail        (fail),
    .end_flag    (end_flag),
    .zombie_lane (zombie_lane),
    .zombie_vld  (zombie_vld),
    .score       (score),
    .lives       (lives)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] step(
    input logic [7:0] v
  );
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // m_prev is the LFSR value just before the latest edge
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= step(m_lfsr);
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic start_game();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m_score  = 0;
    m_lives  = LIV;
    m_rounds = 0;
    chk("start_end", end_flag, 0);
    chk("start_score", score, 0);
    chk("start_lives", lives, LIV);
  endtask

  // kind: 0 none, 1 correct, 2 wrong lane, 3 all lanes
  task automatic play_round(
    input int kind,
    input int dly,
    input bit inj
  );
    int n;
    int at;
    bit shot;
    bit eh;
    bit over;
    logic [1:0] ln;
    logic [1:0] wl;
    logic [3:0] pat;
    n = 0;
    while (zombie_vld !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("vld_rise", zombie_vld, 1);
    if (zombie_vld !== 1'b1) return;
    ln = m_prev[1:0];
    chk("lane", zombie_lane, ln);
    wl = ln + 2'd1;
    case (kind)
      1:       pat = 4'b0001 << ln;
      2:       pat = 4'b0001 << wl;
      3:       pat = 4'hF;
      default: pat = 4'h0;
    endcase
    shot = (kind != 0) && (dly < WIN);
    at   = shot ? dly + 1 : WIN;
    eh   = shot && pat[ln];
    for (int i = 0; i < at; i++) begin
      shoot = (shot && i == dly) ? pat : 4'h0;
      start = inj && (i == 0);
      @(negedge clock);
      if (i + 1 < at) begin
        chk("early_hit", hit, 0);
        chk("early_fail", fail, 0);
        chk("wait_vld", zombie_vld, 1);
      end
    end
    shoot = 4'h0;
    start = 1'b0;
    chk("hit", hit, eh);
    chk("fail", fail, !eh);
    chk("vld_clr", zombie_vld, 0);
    if (eh) m_score = (m_score < 255) ? m_score + 1 : 255;
    else    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    m_rounds++;
    chk("score", score, m_score);
    chk("lives", lives, m_lives);
    over = (m_lives == 0) || (m_rounds == MAXR);
    for (int k = 1; k <= HLD + 1; k++) begin
      shoot = (k <= HLD) ?
              4'($urandom_range(0, 15)) : 4'h0;
      @(negedge clock);
      chk("hold_hit", hit, 0);
      chk("hold_fail", fail, 0);
      if (k < HLD)
        chk("hold_end", end_flag, 0);
      else
        chk("post_end", end_flag, over);
      if (k == HLD + 1)
        chk("respawn", zombie_vld, !over);
    end
    shoot = 4'h0;
  endtask

  task automatic rand_game();
    start_game();
    for (int r = 0; r < MAXR; r++) begin
      if (m_lives == 0 || m_rounds == MAXR) break;
      play_round($urandom_range(0, 3),
                 $urandom_range(0, 9),
                 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 3, 0, 1, 2, 0};
    tbl[1] = '{0, 0, 0, 0, 1, 1, 0};
    tbl[2] = '{0, 3, 7, 0, 2, 1, 1};
    tbl[3] = '{1, 2, 2, 0, 0, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{1, 1, 0, 1, 1, 2, 0};
    tbl[6] = '{0, 1, 5, 1, 2, 2, 0};
    tbl[7] = '{0, 1, 1, 0, 3, 2, 1};

    repeat (3) @(negedge clock);
    chk("rst_end", end_flag, 1);
    chk("rst_lives", lives, LIV);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("idle_end", end_flag, 1);
    chk("idle_score", score, 0);
    chk("idle_lives", lives, LIV);
    chk("idle_vld", zombie_vld, 0);
    chk("idle_hit", hit, 0);
    chk("idle_fail", fail, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].do_start) start_game();
      play_round(tbl[i].kind, tbl[i].dly,
                 tbl[i].inj);
      chk($sformatf("v%0d_score", i),
          score, tbl[i].exp_score);
      chk($sformatf("v%0d_lives", i),
          lives, tbl[i].exp_lives);
      chk($sformatf("v%0d_end", i),
          end_flag, tbl[i].exp_end);
    end

    for (int i = 0; i < 8; i++) begin
      shoot = 4'($urandom_range(1, 15));
      @(negedge clock);
      chk("over_hit", hit, 0);
      chk("over_fail", fail, 0);
    end
    shoot = 4'h0;
    chk("over_score", score, 3);
    chk("over_lives", lives, LIV);
    chk("over_end", end_flag, 1);
    chk("over_vld", zombie_vld, 0);

    for (int g = 0; g < 6; g++) rand_game();

    start_game();
    play_round(1, 2, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_end", end_flag, 1);
    chk("arst_hit", hit, 0);
    chk("arst_fail", fail, 0);
    chk("arst_vld", zombie_vld, 0);
    chk("arst_lane", zombie_lane, 0);
    chk("arst_score", score, 0);
    chk("arst_lives", lives, LIV);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("post_rst_hit", hit, 0);
      chk("post_rst_fail", fail, 0);
      chk("post_rst_end", end_flag, 1);
      chk("post_rst_vld", zombie_vld, 0);
    end

    rand_game();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
